// File: rtl/jt900h_intc.sv
// Priority interrupt controller feeding the jt900h core: edge/level capture, per-source
// levels, vector generation and ack handshake. Optional NMI input under JT900H_INTC_NMI_EN.
module jt900h_intc #(
  parameter int          NSRC      = 8,
  parameter logic [7:0]  VBASE_RST = 8'h40
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic [NSRC-1:0] src,
  input  logic            cfg_we,
  input  logic [3:0]      cfg_addr,
  input  logic [7:0]      cfg_din,
  output logic [7:0]      cfg_dout,
  output logic            irq,
  output logic [2:0]      int_lvl,
  output logic [7:0]      int_addr,
`ifdef JT900H_INTC_NMI_EN
  input  logic            nmi,
`endif
  input  logic            irq_ack
);

  // Core handshake: irq is held with stable int_lvl/int_addr until the core pulses
  // irq_ack for one cen cycle; acks outside PRESENT are ignored.
  typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

  state_t          state;
  logic [NSRC-1:0] src_q, src_hist, pend, edge_mask;
  logic [2:0]      prio [NSRC];
  logic [7:0]      vbase;
  logic [2:0]      cur_idx;
  logic            cur_nmi;
  logic            nmi_pend;

  logic            wr, ack_fire, any_cand, cand_cur;
  logic [NSRC-1:0] rise, cand, w1c, ack_clr, idx_dec, pend_nxt;
  logic [2:0]      best_idx, best_lvl;
  logic [7:0]      pend_rd;

  assign wr       = cen & cfg_we;
  assign ack_fire = cen & irq_ack & (state == PRESENT);
  assign rise     = src_q & ~src_hist;
  assign w1c      = (wr && cfg_addr == 4'd11) ? cfg_din[NSRC-1:0] : '0;

  always_comb begin
    idx_dec = '0;
    cand    = '0;
    for (int i = 0; i < NSRC; i++) begin
      idx_dec[i] = (cur_idx == 3'(i));
      cand[i]    = pend[i] & (prio[i] != 3'd0);
    end
  end

  assign cand_cur = |(cand & idx_dec);
  assign ack_clr  = (ack_fire && !cur_nmi) ? (idx_dec & edge_mask) : '0;
  // A fresh edge in the same cycle as a clear keeps the request pending.
  assign pend_nxt = (edge_mask & (rise | (pend & ~w1c & ~ack_clr))) | (~edge_mask & src_q);

  // Scan from the top index down with >= so that ties settle on the lowest index.
  always_comb begin
    best_idx = 3'd0;
    best_lvl = 3'd0;
    any_cand = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i] && prio[i] >= best_lvl) begin
        best_idx = 3'(i);
        best_lvl = prio[i];
        any_cand = 1'b1;
      end
    end
  end

`ifdef JT900H_INTC_NMI_EN
  logic nmi_q, nmi_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_q    <= 1'b0;
      nmi_hist <= 1'b0;
      nmi_pend <= 1'b0;
    end else if (cen) begin
      nmi_q    <= nmi;
      nmi_hist <= nmi_q;
      nmi_pend <= (nmi_q & ~nmi_hist) | (nmi_pend & ~(ack_fire & cur_nmi));
    end
  end
`else
  assign nmi_pend = 1'b0;
`endif

  always_comb begin
    pend_rd = 8'(pend);
`ifdef JT900H_INTC_NMI_EN
    if (NSRC < 8) pend_rd[7] = nmi_pend;
`endif
  end

  always_comb begin
    cfg_dout = 8'd0;
    for (int i = 0; i < NSRC; i++) begin
      if (cfg_addr == 4'(i)) cfg_dout = {5'd0, prio[i]};
    end
    case (cfg_addr)
      4'd8:    cfg_dout = vbase;
      4'd9:    cfg_dout = pend_rd;
      4'd10:   cfg_dout = 8'(edge_mask);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      src_hist  <= '0;
      pend      <= '0;
      edge_mask <= '1;
      vbase     <= VBASE_RST;
      for (int i = 0; i < NSRC; i++) prio[i] <= 3'd0;
    end else if (cen) begin
      src_q    <= src;
      src_hist <= src_q;
      pend     <= pend_nxt;
      if (wr) begin
        for (int i = 0; i < NSRC; i++) begin
          if (cfg_addr == 4'(i)) prio[i] <= cfg_din[2:0];
        end
        if (cfg_addr == 4'd8)  vbase     <= cfg_din;
        if (cfg_addr == 4'd10) edge_mask <= cfg_din[NSRC-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      irq      <= 1'b0;
      int_lvl  <= 3'd0;
      int_addr <= 8'd0;
      cur_idx  <= 3'd0;
      cur_nmi  <= 1'b0;
    end else if (cen) begin
      case (state)
        IDLE: begin
          if (nmi_pend) begin
            irq      <= 1'b1;
            int_lvl  <= 3'd7;
            int_addr <= {vbase[7:5], 5'h1C};
            cur_nmi  <= 1'b1;
            state    <= PRESENT;
          end else if (any_cand) begin
            irq      <= 1'b1;
            int_lvl  <= best_lvl;
            int_addr <= {vbase[7:5], best_idx, 2'b00};
            cur_idx  <= best_idx;
            cur_nmi  <= 1'b0;
            state    <= PRESENT;
          end
        end
        PRESENT: begin
          if (irq_ack) begin
            irq   <= 1'b0;
            state <= GAP;
          end else if (!cur_nmi && !cand_cur) begin
            irq   <= 1'b0;
            state <= IDLE;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
